// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 1-cycle-latency data RAM.
// Port 0 is the core load/store unit, port 1 the debug/loader master.
module dram_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  input  logic [BE_WIDTH-1:0]   m0_req_be,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,

  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  input  logic [BE_WIDTH-1:0]   m1_req_be,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,

  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  logic                  last_grant;
  logic [1:0]            rsp_pend;
  logic [1:0]            rsp_rd;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic                  gnt0;
  logic                  gnt1;

  // Stage p0: combinational arbitration and RAM drive in the request cycle
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (m0_req_valid && m1_req_valid) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = m0_req_valid;
        gnt1 = m1_req_valid;
      end
    end
  end

  assign m0_req_ready = gnt0;
  assign m1_req_ready = gnt1;

  // Idle cycles keep the last address so the RAM output does not toggle.
  always_comb begin
    ram_addr       = addr_hold;
    ram_wr_data    = '0;
    ram_wr_en      = 1'b0;
    ram_wr_byte_en = '0;
    if (gnt0) begin
      ram_addr       = m0_req_addr;
      ram_wr_data    = m0_req_wdata;
      ram_wr_en      = m0_req_we;
      ram_wr_byte_en = m0_req_be;
    end else if (gnt1) begin
      ram_addr       = m1_req_addr;
      ram_wr_data    = m1_req_wdata;
      ram_wr_en      = m1_req_we;
      ram_wr_byte_en = m1_req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      rsp_pend   <= 2'b00;
      rsp_rd     <= 2'b00;
      addr_hold  <= '0;
    end else begin
      rsp_pend <= {gnt1, gnt0};
      rsp_rd   <= {gnt1 & ~m1_req_we, gnt0 & ~m0_req_we};
      if (gnt0 || gnt1) begin
        last_grant <= gnt1;
        addr_hold  <= ram_addr;
      end
    end
  end

  // Stage p1: route RAM read data to the requester granted one cycle earlier
  assign m0_rsp_valid = rsp_pend[0] & ~rst;
  assign m1_rsp_valid = rsp_pend[1] & ~rst;
  assign m0_rsp_rdata = (rsp_rd[0] && !rst) ? ram_rd_data : '0;
  assign m1_rsp_rdata = (rsp_rd[1] && !rst) ? ram_rd_data : '0;

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Two-requester arbiter in front of the single-port data RAM (8K x 32, 4 byte lanes, 1-cycle read latency, no output register).
- Port 0 is the core load/store unit. Port 1 is the debug/loader master.
- Each cycle the block grants at most one request, drives the RAM address, write and byte-enable pins, and routes the read data back to the granted requester one cycle later.
- Round-robin fairness applies when both ports request in the same cycle.

Parameters:
- ADDR_WIDTH, 13, word address width into the RAM.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, 4, byte-enable width (DATA_WIDTH/8).

Ports:
- clk  input  1  single clock for the block and the RAM.
- rst  input  1  synchronous, active-high reset.
- m0_req_valid  input  1  port 0 request present.
- m0_req_ready  output  1  port 0 request accepted this cycle.
- m0_req_we  input  1  1 = write, 0 = read.
- m0_req_addr  input  ADDR_WIDTH  word address.
- m0_req_wdata  input  DATA_WIDTH  write data.
- m0_req_be  input  BE_WIDTH  byte write enables.
- m0_rsp_valid  output  1  response for the previously accepted port 0 request.
- m0_rsp_rdata  output  DATA_WIDTH  read data; 0 when not a read response.
- m1_req_valid, m1_req_ready, m1_req_we, m1_req_addr, m1_req_wdata, m1_req_be, m1_rsp_valid, m1_rsp_rdata: same directions and widths as port 0, for port 1.
- ram_addr  output  ADDR_WIDTH  to RAM addr.
- ram_wr_data  output  DATA_WIDTH  to RAM wr_data.
- ram_wr_en  output  1  to RAM wr_en.
- ram_wr_byte_en  output  BE_WIDTH  to RAM wr_byte_en.
- ram_rd_data  input  DATA_WIDTH  from RAM rd_data; valid 1 cycle after the address.

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high.
- State registers:
  - last_grant (1 bit; reset value 1, so port 0 wins the first contention).
  - rsp_pend (2 bits, one per port; reset 0).
  - rsp_rd (2 bits; reset 0).
- Arbitration is combinational in the request cycle:
  - Only m0_req_valid high: grant port 0.
  - Only m1_req_valid high: grant port 1.
  - Both high: grant the port not equal to last_grant.
  - Neither high: no grant.
- mX_req_ready is high only for the granted port. The request is accepted in the cycle where valid && ready.
- last_grant updates to the granted port on every grant and holds otherwise.
- RAM drive:
  - ram_addr, ram_wr_data and ram_wr_byte_en equal the granted port's fields.
  - ram_wr_en = granted && req_we.
  - With no grant: ram_wr_en = 0, ram_wr_byte_en = 0, and ram_addr holds the last granted address (registered copy, reset 0) so the RAM output is not needlessly toggled.
- Response:
  - On acceptance, rsp_pend[X] <= 1 and rsp_rd[X] <= ~req_we; the other port's bits <= 0.
  - In the next cycle, mX_rsp_valid = rsp_pend[X], and mX_rsp_rdata = rsp_rd[X] ? ram_rd_data : 0.
  - Read latency is 1 cycle from acceptance to rsp_valid. Writes also get a 1-cycle ack.
- Throughput: one accepted request per cycle, sustained. Back-to-back requests from the same port are granted every cycle if the other port is idle.
- No response backpressure: requesters must take the response in the cycle rsp_valid is high.
- Requester rule: a requester holds valid and all fields stable until ready. The arbiter does not register requests, so a dropped valid simply withdraws the request.
- Write with req_be = 0: accepted, ram_wr_en = 1 with all byte enables 0, no memory change, ack returned.
- Read-after-write to the same address in consecutive cycles: the read returns the newly written data, because the RAM is single-port and the write completes at the first edge.
- While rst = 1:
  - Both readies are forced 0, ram_wr_en = 0, ram_wr_byte_en = 0.
  - All registers load their reset values.
  - A response due in the reset cycle is dropped (rsp_valid stays 0).
- After rst deasserts, arbitration resumes the next cycle with port 0 priority.

Test Plan:
- Reset, then port 0 writes addr 0x0010 data 0xDEADBEEF be 0xF, then reads 0x0010 -> m0_req_ready high in both request cycles; m0_rsp_valid 1 cycle after each; the read returns m0_rsp_rdata = 0xDEADBEEF; the write ack has rdata = 0.
- Byte lanes: write 0x11223344 be 0xF to 0x0020, then 0xAABBCCDD be 0x5, then read -> 0x11BB33DD.
- Contention: both ports request reads of 0x0001 and 0x0002 every cycle for 4 cycles, starting just after reset -> grants alternate 0,1,0,1; each port's rsp_valid follows 1 cycle after its grant; no request is lost; m1's data is delivered only on m1_rsp_rdata.
- Single-port streaming: port 1 reads 0x1FFE, 0x1FFF, 0x0000 on consecutive cycles with port 0 idle -> 3 consecutive grants and 3 consecutive rsp_valid cycles with the correct data, including at top-of-memory 0x1FFF.
- Reset mid-operation: accept a port 0 read at cycle N and assert rst at cycle N+1 -> m0_rsp_valid = 0 at N+1, ram_wr_en = 0 while in reset; after release, contention is granted to port 0 first.
- Zero byte-enable write: port 1 writes be 0x0 with data 0xFFFFFFFF to an address holding 0x12345678 -> ack given; a subsequent read returns 0x12345678.
